// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane stores and sign/zero-extended loads per RISC-V func3.
// Latency: stall for WAIT_CYCLES+2 cycles, then one-cycle ack; illegal requests get err in the same cycle.
module dmem_responder #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        MemWrite,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam int         DEPTH     = 1 << ADDR_BITS;

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic        op_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        legal;
  logic        capture;
  logic        access;
  logic        stall_c, ack_c, err_c;

  logic [31:0] mem [0:DEPTH-1];
  logic [ADDR_BITS-1:0] widx;
  logic [3:0]  be;
  logic [31:0] wlane;
  logic [31:0] rword;
  logic [31:0] rshift;
  logic [31:0] ld_val;

  always_comb begin
    legal = 1'b0;
    case (func3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~addr[0];
      3'b010:  legal = (addr[1:0] == 2'b00);
      3'b100:  legal = ~MemWrite;
      3'b101:  legal = ~MemWrite & ~addr[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    stall_c  = 1'b0;
    ack_c    = 1'b0;
    err_c    = 1'b0;
    capture  = 1'b0;
    access   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (legal) begin
            stall_c  = 1'b1;
            capture  = 1'b1;
            state_nx = BUSY;
          end else begin
            err_c = 1'b1;
          end
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (cnt == 4'd0) begin
          access   = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        // req_valid still reflects the instruction just served; ignore it.
        ack_c    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign stall = rst & stall_c;
  assign ack   = rst & ack_c;
  assign err   = rst & err_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      op_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata   <= 32'd0;
    end else begin
      state <= state_nx;
      if (capture) begin
        cnt     <= WAIT_INIT;
        op_q    <= MemWrite;
        f3_q    <= func3;
        addr_q  <= addr;
        wdata_q <= wdata;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access && !op_q) begin
        rdata <= ld_val;
      end
    end
  end

  // Upper address bits beyond the array are dropped, so addresses wrap.
  assign widx = addr_q[ADDR_BITS+1:2];

  always_comb begin
    be    = 4'b1111;
    wlane = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_q[1:0];
        wlane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdata_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (access && op_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  always_comb begin
    rword  = mem[widx];
    rshift = rword >> {addr_q[1:0], 3'b000};
    ld_val = rword;
    case (f3_q)
      3'b000:  ld_val = {{24{rshift[7]}}, rshift[7:0]};
      3'b100:  ld_val = {24'd0, rshift[7:0]};
      3'b001:  ld_val = {{16{rshift[15]}}, rshift[15:0]};
      3'b101:  ld_val = {16'd0, rshift[15:0]};
      default: ld_val = rword;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (WAIT_CYCLES 1, 0, 3) checked against a byte-level model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  rv;
  logic        mw;
  logic [2:0]  func3;
  logic [31:0] addr, wdata;
  logic [2:0]  stall_v, ack_v, err_v;
  logic [31:0] rdata_a [3];

  int          cur = 0;
  logic        stall_s, ack_s, err_s;
  logic [31:0] rdata_s;
  assign stall_s = stall_v[cur];
  assign ack_s   = ack_v[cur];
  assign err_s   = err_v[cur];
  assign rdata_s = rdata_a[cur];

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];
  logic [7:0]  mdl [int];
  int          waits [3] = '{1, 0, 3};

  dmem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .MemWrite(mw), .func3(func3), .addr(addr),
    .wdata(wdata), .stall(stall_v[0]), .ack(ack_v[0]), .rdata(rdata_a[0]), .err(err_v[0]));
  dmem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .MemWrite(mw), .func3(func3), .addr(addr),
    .wdata(wdata), .stall(stall_v[1]), .ack(ack_v[1]), .rdata(rdata_a[1]), .err(err_v[1]));
  dmem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .req_valid(rv[2]), .MemWrite(mw), .func3(func3), .addr(addr),
    .wdata(wdata), .stall(stall_v[2]), .ack(ack_v[2]), .rdata(rdata_a[2]), .err(err_v[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mbyte(input int k);
    if (mdl.exists(k)) return mdl[k];
    return 8'h00;
  endfunction

  // Model keeps one 4 KiB byte space per instance; addr[11:0] gives the wrap.
  task automatic mdl_store(input int sel, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int k;
    k = sel * 4096 + int'(a[11:0]);
    mdl[k] = d[7:0];
    if (f3 != 3'b000) mdl[k+1] = d[15:8];
    if (f3 == 3'b010) begin
      mdl[k+2] = d[23:16];
      mdl[k+3] = d[31:24];
    end
  endtask

  function automatic logic [31:0] mdl_load(input int sel, input logic [2:0] f3, input logic [31:0] a);
    int k;
    logic [7:0]  b;
    logic [15:0] h;
    k = sel * 4096 + int'(a[11:0]);
    b = mbyte(k);
    h = {mbyte(k+1), mbyte(k)};
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return {mbyte(k+3), mbyte(k+2), mbyte(k+1), mbyte(k)};
    endcase
  endfunction

  task automatic run_req(input int sel, input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic exp_err, output logic [31:0] rd);
    int n_stall;
    bit seen_ack;
    n_stall  = 0;
    seen_ack = 1'b0;
    rd       = 32'd0;
    @(posedge clk); #1;
    cur = sel; rv = 3'b000; rv[sel] = 1'b1;
    mw = we; func3 = f3; addr = a; wdata = d;
    if (!exp_err) begin
      if (we) mdl_store(sel, f3, a, d);
      else    exp_q.push_back(mdl_load(sel, f3, a));
    end
    @(negedge clk);
    check("err_req_cycle", 32'(err_s), 32'(exp_err));
    check("stall_req_cycle", 32'(stall_s), 32'(!exp_err));
    if (stall_s) n_stall++;
    @(posedge clk); #1;
    rv = 3'b000; mw = 1'($urandom); func3 = 3'($urandom); addr = $urandom; wdata = $urandom;
    for (int i = 0; i < (exp_err ? 6 : 40) && !seen_ack; i++) begin
      @(negedge clk);
      if (ack_s) seen_ack = 1'b1;
      else if (stall_s) n_stall++;
    end
    if (exp_err) begin
      check("err_no_ack", 32'(seen_ack), 32'd0);
      check("err_no_stall", 32'(n_stall), 32'd0);
    end else begin
      check("ack_seen", 32'(seen_ack), 32'd1);
      check("stall_len", 32'(n_stall), 32'(waits[sel] + 2));
      if (!we && seen_ack) begin
        rd = rdata_s;
        if (exp_q.size() > 0) check("rdata", rdata_s, exp_q.pop_front());
        else check("rdata_queue", 32'(exp_q.size()), 32'd1);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    rst = 1'b0; rv = 3'b000; mw = 1'b0; func3 = 3'b000; addr = 32'd0; wdata = 32'd0;
    #12;
    for (int s = 0; s < 3; s++) begin
      check("rst_stall", 32'(stall_v[s]), 32'd0);
      check("rst_ack", 32'(ack_v[s]), 32'd0);
      check("rst_err", 32'(err_v[s]), 32'd0);
      check("rst_rdata", rdata_a[s], 32'd0);
    end
    @(negedge clk); rst = 1'b1;

    // Basic word store/load
    run_req(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, rd);
    run_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd);
    check("t1_lw_const", rd, 32'hDEADBEEF);

    // Byte lanes and extension
    run_req(0, 1'b1, 3'b010, 32'h20, 32'h0, 1'b0, rd);
    run_req(0, 1'b1, 3'b000, 32'h23, 32'h80, 1'b0, rd);
    run_req(0, 1'b0, 3'b000, 32'h23, 32'h0, 1'b0, rd);
    check("t2_lb_const", rd, 32'hFFFFFF80);
    run_req(0, 1'b0, 3'b100, 32'h23, 32'h0, 1'b0, rd);
    check("t2_lbu_const", rd, 32'h00000080);
    run_req(0, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, rd);
    check("t2_lw_const", rd, 32'h80000000);

    // Halfword lanes
    run_req(0, 1'b1, 3'b010, 32'h40, 32'h0000CAFE, 1'b0, rd);
    run_req(0, 1'b1, 3'b001, 32'h42, 32'h00008001, 1'b0, rd);
    run_req(0, 1'b0, 3'b001, 32'h42, 32'h0, 1'b0, rd);
    check("t3_lh_const", rd, 32'hFFFF8001);
    run_req(0, 1'b0, 3'b101, 32'h42, 32'h0, 1'b0, rd);
    run_req(0, 1'b0, 3'b010, 32'h40, 32'h0, 1'b0, rd);
    check("t3_lw_const", rd, 32'h8001CAFE);
    run_req(0, 1'b1, 3'b000, 32'h41, 32'h000000EE, 1'b0, rd);
    run_req(0, 1'b0, 3'b101, 32'h40, 32'h0, 1'b0, rd);

    // Illegal requests: no access, array untouched
    run_req(0, 1'b0, 3'b001, 32'h41, 32'h0, 1'b1, rd);
    run_req(0, 1'b0, 3'b010, 32'h22, 32'h0, 1'b1, rd);
    run_req(0, 1'b0, 3'b011, 32'h20, 32'h0, 1'b1, rd);
    run_req(0, 1'b1, 3'b100, 32'h20, 32'h11, 1'b1, rd);
    run_req(0, 1'b1, 3'b010, 32'h21, 32'h11111111, 1'b1, rd);
    run_req(0, 1'b1, 3'b001, 32'h23, 32'h2222, 1'b1, rd);
    run_req(0, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, rd);
    check("t4_unchanged_const", rd, 32'h80000000);

    // Reset during BUSY aborts a store before its access edge
    run_req(0, 1'b1, 3'b010, 32'h04, 32'h11112222, 1'b0, rd);
    @(posedge clk); #1;
    cur = 0; rv = 3'b001; mw = 1'b1; func3 = 3'b010; addr = 32'h04; wdata = 32'h12345678;
    @(posedge clk); #1;
    rv = 3'b000;
    rst = 1'b0;
    #1;
    check("t5_rst_stall", 32'(stall_s), 32'd0);
    check("t5_rst_ack", 32'(ack_s), 32'd0);
    check("t5_rst_rdata", rdata_s, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("t5_rst_hold_stall", 32'(stall_s), 32'd0);
    rst = 1'b1;
    run_req(0, 1'b0, 3'b010, 32'h04, 32'h0, 1'b0, rd);
    check("t5_old_const", rd, 32'h11112222);

    // Address wrap
    run_req(0, 1'b1, 3'b010, 32'h1004, 32'hA5A5A5A5, 1'b0, rd);
    run_req(0, 1'b0, 3'b010, 32'h0004, 32'h0, 1'b0, rd);
    check("t6_wrap_const", rd, 32'hA5A5A5A5);

    // Wait-state sweep on the other instances
    run_req(1, 1'b1, 3'b010, 32'h08, 32'h55AA55AA, 1'b0, rd);
    run_req(1, 1'b0, 3'b000, 32'h09, 32'h0, 1'b0, rd);
    run_req(1, 1'b0, 3'b011, 32'h08, 32'h0, 1'b1, rd);
    run_req(2, 1'b1, 3'b010, 32'h0C, 32'hC3C3F00F, 1'b0, rd);
    run_req(2, 1'b0, 3'b001, 32'h0E, 32'h0, 1'b0, rd);
    run_req(2, 1'b0, 3'b010, 32'h0C, 32'h0, 1'b0, rd);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
